neopixel_array: RTL and testbench



---
 rtl/neopixel_array.sv | 216 +++++++++++++++++++++
 tb/tb_neopixel_array.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_array.sv
// neopixel_array: multi-channel WS2812-class LED driver with an Avalon-MM
// register slave. All channels shift out the same pixel index in lockstep.
// Each byte is scaled by a global brightness, frames can auto-refresh, and
// start requests made while busy are queued as a single pending frame.
module neopixel_array #(
  parameter int NUM_CHANNELS = 4,
  parameter int PIXELS       = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int BIT_CYCLES   = 62,
  parameter int LATCH_CYCLES = 15000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   avalon_slave_address,
  input  logic                    avalon_slave_write,
  input  logic [31:0]             avalon_slave_writedata,
  input  logic                    avalon_slave_read,
  output logic [31:0]             avalon_slave_readdata,
  output logic                    avalon_slave_waitrequest,
  output logic [NUM_CHANNELS-1:0] one_wire
);

  localparam int NPIX   = NUM_CHANNELS * PIXELS;
  localparam int PIX_AW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PX_W   = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_LATCH} state_t;

  state_t                  state_q, state_d;
  logic [PX_W-1:0]         px_q, px_d;
  logic [4:0]              bit_q, bit_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [23:0]             shreg_q [NUM_CHANNELS];
  logic [23:0]             shreg_d [NUM_CHANNELS];
  logic [23:0]             pix_q [NPIX];
  logic [23:0]             pix_d [NPIX];
  logic [7:0]              bright_q, bright_d;
  logic                    auto_q, auto_d;
  logic                    pend_q, pend_d;
  logic [15:0]             frame_q, frame_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [NUM_CHANNELS-1:0] wire_q, wire_d;

  logic [ADDR_WIDTH-1:0]   pidx;
  logic [PIX_AW-1:0]       pidx_s;
  logic                    in_pix;
  logic                    ctrl_wr;
  logic                    start_wr;
  logic                    start_req;
  logic                    busy;
  logic [23:0]             load_val [NUM_CHANNELS];
  logic                    unused_bits;

  // c' = (c * (b + 1)) >> 8, evaluated at 17 bits so b = 0xFF is identity.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    scale8 = 8'((17'(c) * (17'(b) + 17'd1)) >> 8);
  endfunction

  assign avalon_slave_waitrequest = 1'b0;
  assign avalon_slave_readdata    = rdata_q;
  assign one_wire                 = wire_q;

  assign pidx      = avalon_slave_address - ADDR_WIDTH'(8);
  assign pidx_s    = pidx[PIX_AW-1:0];
  assign in_pix    = (avalon_slave_address >= ADDR_WIDTH'(8)) && (32'(pidx) < 32'(NPIX));
  assign ctrl_wr   = avalon_slave_write && (avalon_slave_address == ADDR_WIDTH'(0));
  assign start_wr  = ctrl_wr && avalon_slave_writedata[0];
  assign start_req = start_wr || pend_q;
  assign busy      = (state_q != S_IDLE);

  assign unused_bits = ^{avalon_slave_writedata[31:24], avalon_slave_writedata[7:2]};

  // Per-channel scaled copy of the pixel at the current index, latched in LOAD.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [23:0] raw;
      assign raw = pix_q[PIX_AW'(gi * PIXELS) + PIX_AW'(px_q)];
      assign load_val[gi] = {scale8(raw[23:16], bright_q),
                             scale8(raw[15:8],  bright_q),
                             scale8(raw[7:0],   bright_q)};
    end
  endgenerate

  // Register writes, readback mux, frame sequencing and next one_wire levels.
  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    pix_d    = pix_q;
    bright_d = bright_q;
    auto_d   = auto_q;
    pend_d   = pend_q;
    frame_d  = frame_q;
    rdata_d  = rdata_q;
    wire_d   = '0;

    if (avalon_slave_write && in_pix) begin
      pix_d[pidx_s] = avalon_slave_writedata[23:0];
    end
    if (ctrl_wr) begin
      auto_d   = avalon_slave_writedata[1];
      bright_d = avalon_slave_writedata[15:8];
    end
    // Starts while busy coalesce into one pending frame.
    if (start_wr && busy) begin
      pend_d = 1'b1;
    end

    if (avalon_slave_read) begin
      rdata_d = '0;
      if (avalon_slave_address == ADDR_WIDTH'(0)) begin
        rdata_d = {16'h0, bright_q, 6'h0, auto_q, 1'b0};
      end else if (avalon_slave_address == ADDR_WIDTH'(1)) begin
        rdata_d = {frame_q, 14'h0, pend_q, busy};
      end else if (in_pix) begin
        rdata_d = {8'h0, pix_q[pidx_s]};
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_LOAD;
          px_d    = '0;
          pend_d  = 1'b0;
        end
      end
      S_LOAD: begin
        shreg_d = load_val;
        bit_d   = 5'd23;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (cnt_q == 32'(BIT_CYCLES - 1)) begin
          cnt_d = '0;
          for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            shreg_d[ch] = {shreg_q[ch][22:0], 1'b0};
          end
          if (bit_q == 5'd0) begin
            if (px_q == PX_W'(PIXELS - 1)) begin
              state_d = S_LATCH;
            end else begin
              px_d    = px_q + PX_W'(1);
              state_d = S_LOAD;
            end
          end else begin
            bit_d = bit_q - 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_LATCH: begin
        if (cnt_q == 32'(LATCH_CYCLES - 1)) begin
          cnt_d   = '0;
          frame_d = frame_q + 16'd1;
          // A pending start and auto_refresh together still give one frame.
          if (start_req || auto_q) begin
            state_d = S_LOAD;
            px_d    = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they change cleanly on the edge.
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      wire_d[ch] = (state_d == S_SEND) &&
                   (cnt_d < (shreg_d[ch][23] ? 32'(T1H_CYCLES) : 32'(T0H_CYCLES)));
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      px_q     <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      bright_q <= 8'hFF;
      auto_q   <= 1'b0;
      pend_q   <= 1'b0;
      frame_q  <= '0;
      rdata_q  <= '0;
      wire_q   <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) shreg_q[i] <= '0;
      for (int i = 0; i < NPIX; i++) pix_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      bright_q <= bright_d;
      auto_q   <= auto_d;
      pend_q   <= pend_d;
      frame_q  <= frame_d;
      rdata_q  <= rdata_d;
      wire_q   <= wire_d;
      shreg_q  <= shreg_d;
      pix_q    <= pix_d;
    end
  end

endmodule

// File: tb/tb_neopixel_array.sv
// Directed testbench for neopixel_array with reduced PIXELS/LATCH_CYCLES so
// that several whole frames fit in a short run.
module tb_neopixel_array;

  localparam int NCH       = 4;
  localparam int PIX       = 4;
  localparam int LATCH     = 1000;
  localparam int FRAME_LEN = PIX * (1 + 24 * 62) + LATCH;

  logic        clk;
  logic        reset;
  logic [7:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [NCH-1:0] one_wire;

  int n_checks;
  int n_fail;
  int bad_widths;

  int unsigned hcnt [NCH];
  int unsigned widths [NCH][$];

  neopixel_array #(
    .NUM_CHANNELS(NCH), .PIXELS(PIX), .ADDR_WIDTH(8),
    .T0H_CYCLES(20), .T1H_CYCLES(40), .BIT_CYCLES(62), .LATCH_CYCLES(LATCH)
  ) dut (
    .clock(clk),
    .reset(reset),
    .avalon_slave_address(address),
    .avalon_slave_write(write),
    .avalon_slave_writedata(writedata),
    .avalon_slave_read(read),
    .avalon_slave_readdata(readdata),
    .avalon_slave_waitrequest(waitrequest),
    .one_wire(one_wire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record the width of every high pulse on each channel.
  always @(negedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (one_wire[ch]) begin
          hcnt[ch]++;
        end else if (hcnt[ch] != 0) begin
          widths[ch].push_back(hcnt[ch]);
          hcnt[ch] = 0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("check %s: %08h ok", tag, got);
    end
  endtask

  task automatic avm_write(input logic [7:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic avm_read(input logic [7:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  // Poll STATUS until frame_count reaches target or the cycle budget runs out.
  task automatic wait_frame(input int target, output logic [31:0] st);
    st = '0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      avm_read(8'd1, st);
      if (st[31:16] == 16'(target)) break;
    end
  endtask

  task automatic clear_mon();
    for (int ch = 0; ch < NCH; ch++) begin
      widths[ch].delete();
      hcnt[ch] = 0;
    end
  endtask

  // Turn 24 recorded pulses back into a pixel value (MSB first).
  task automatic decode(input int ch, input int px, output logic [23:0] v);
    int unsigned w;
    int idx;
    v = '0;
    for (int b = 0; b < 24; b++) begin
      idx = px * 24 + b;
      w = (idx < widths[ch].size()) ? widths[ch][idx] : 0;
      if (w == 40) v[23 - b] = 1'b1;
      else if (w != 20) bad_widths++;
    end
  endtask

  logic [31:0] rd;
  logic [23:0] pv;

  initial begin
    n_checks = 0; n_fail = 0; bad_widths = 0;
    reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
    for (int ch = 0; ch < NCH; ch++) hcnt[ch] = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_readdata", readdata, 32'h0);
    check_eq("reset_one_wire", 32'(one_wire), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    avm_read(8'd0, rd); check_eq("reset_ctrl", rd, 32'h0000FF00);
    avm_read(8'd1, rd); check_eq("reset_status", rd, 32'h0);

    // Frame 1: single pixel, start timing, frame_count timing.
    avm_write(8'd8, 32'h00800001);
    avm_read(8'd8, rd); check_eq("px_readback", rd, 32'h00800001);
    clear_mon();
    avm_write(8'd0, 32'h0000FF01);
    check_eq("load_low", 32'(one_wire), 32'h0);
    avm_read(8'd1, rd);
    check_eq("busy_n1", rd, 32'h00000001);
    check_eq("rise_n2", 32'(one_wire[0]), 32'h1);
    repeat (FRAME_LEN - 2) @(negedge clk);
    avm_read(8'd1, rd); check_eq("frame_last_cycle", rd, 32'h00000001);
    avm_read(8'd1, rd); check_eq("frame_done", rd, 32'h00010000);
    check_eq("ch0_pulses", widths[0].size(), 32'(PIX * 24));
    check_eq("ch3_pulses", widths[3].size(), 32'(PIX * 24));
    decode(0, 0, pv); check_eq("f1_ch0_px0", 32'(pv), 32'h800001);
    decode(0, 1, pv); check_eq("f1_ch0_px1", 32'(pv), 32'h0);
    decode(1, 0, pv); check_eq("f1_ch1_px0", 32'(pv), 32'h0);
    decode(3, 3, pv); check_eq("f1_ch3_px3", 32'(pv), 32'h0);

    // Frame 2: brightness 0x7F, top byte dropped, reserved/out-of-range access.
    avm_write(8'd0, 32'h00007F00);
    avm_write(8'd14, 32'hAAFF8002);
    avm_read(8'd14, rd); check_eq("px_top_byte", rd, 32'h00FF8002);
    avm_write(8'd5, 32'h12345678);
    avm_read(8'd5, rd); check_eq("reserved_rd", rd, 32'h0);
    avm_write(8'd24, 32'h00FFFFFF);
    avm_read(8'd24, rd); check_eq("beyond_rd", rd, 32'h0);
    avm_read(8'd0, rd); check_eq("ctrl_bright", rd, 32'h00007F00);
    clear_mon();
    avm_write(8'd0, 32'h00007F01);
    wait_frame(2, rd); check_eq("f2_status", rd, 32'h00020000);
    decode(1, 2, pv); check_eq("f2_ch1_px2", 32'(pv), 32'h7F4001);
    decode(0, 0, pv); check_eq("f2_ch0_px0", 32'(pv), 32'h400000);
    decode(1, 0, pv); check_eq("f2_ch1_px0", 32'(pv), 32'h0);
    check_eq("pulse_widths", 32'(bad_widths), 32'h0);

    // Frames 3-4: queued start requests coalesce into one extra frame.
    avm_write(8'd0, 32'h0000FF01);
    repeat (100) @(negedge clk);
    avm_write(8'd0, 32'h0000FF01);
    avm_read(8'd1, rd); check_eq("pending_set", rd, 32'h00020003);
    avm_write(8'd0, 32'h0000FF01);
    avm_read(8'd1, rd); check_eq("pending_coalesce", rd, 32'h00020003);
    wait_frame(3, rd); check_eq("pending_restart", rd, 32'h00030001);
    wait_frame(4, rd); check_eq("pending_done", rd, 32'h00040000);
    repeat (50) @(negedge clk);
    avm_read(8'd1, rd); check_eq("stay_idle", rd, 32'h00040000);

    // Frames 5-8: auto refresh runs back to back until cleared.
    avm_write(8'd0, 32'h0000FF02);
    avm_read(8'd1, rd); check_eq("auto_no_start", rd, 32'h00040000);
    avm_write(8'd0, 32'h0000FF03);
    wait_frame(5, rd); check_eq("auto_f5", rd, 32'h00050001);
    wait_frame(6, rd); check_eq("auto_f6", rd, 32'h00060001);
    wait_frame(7, rd); check_eq("auto_f7", rd, 32'h00070001);
    avm_read(8'd0, rd); check_eq("ctrl_auto", rd, 32'h0000FF02);
    avm_write(8'd0, 32'h0000FF00);
    wait_frame(8, rd); check_eq("auto_stop", rd, 32'h00080000);

    // Reset while sending.
    avm_write(8'd0, 32'h0000FF01);
    repeat (5) @(negedge clk);
    check_eq("send_high", 32'(one_wire[0]), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_one_wire", 32'(one_wire), 32'h0);
    reset = 1'b0;
    avm_read(8'd1, rd); check_eq("rst_status", rd, 32'h0);
    avm_read(8'd0, rd); check_eq("rst_ctrl", rd, 32'h0000FF00);
    avm_read(8'd8, rd); check_eq("rst_px0", rd, 32'h0);
    avm_read(8'd14, rd); check_eq("rst_px14", rd, 32'h0);
    repeat (100) @(negedge clk);
    check_eq("rst_quiet", 32'(one_wire), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
